// File: rtl/led_seq_wbm.sv
// led_seq_wbm: Wishbone master that animates the board LED register.
// A prescaler produces step ticks; each tick launches one single-beat write
// of the next pattern for the selected mode to LED_ADDR.
module led_seq_wbm #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR     = '0,
  parameter int                    STEP_CYCLES  = 25000000,
  parameter int                    ACK_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    wb_we_o,
  output logic [SELECT_WIDTH-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    i_enable,
  input  logic [1:0]              i_mode,
  input  logic [6:0]              i_status,
  input  logic                    i_clr_err,
  output logic                    o_busy,
  output logic                    o_timeout_err,
  output logic                    o_bus_err
);

  localparam int PRE_W = $clog2(STEP_CYCLES);
  localparam int TO_W  = $clog2(ACK_TIMEOUT);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_STATUS = 2'd3;

  typedef enum logic [0:0] {ST_IDLE, ST_REQ} state_t;

  state_t              state_reg, state_next;
  logic [PRE_W-1:0]    pre_cnt_reg, pre_cnt_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic                pending_reg, pending_next;
  logic [1:0]          walk_idx_reg, walk_idx_next;
  logic                blink_reg, blink_next;
  logic [1:0]          prev_mode_reg, prev_mode_next;
  logic                mode_valid_reg, mode_valid_next;
  logic                bus_reg, bus_next;
  logic [DATA_WIDTH-1:0] dat_reg, dat_next;
  logic                to_err_reg, to_err_next;
  logic                bus_err_reg, bus_err_next;

  logic       tick;
  logic       launch;
  logic       restart;
  logic [1:0] walk_idx_sel;
  logic       blink_sel;
  logic [3:0] walk_onehot;
  logic [6:0] pattern;
  logic       set_to;
  logic       set_be;

  // Read data is never consumed by a write-only master.
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;

  assign wb_adr_o      = LED_ADDR;
  assign wb_sel_o      = '1;
  assign wb_cyc_o      = bus_reg;
  assign wb_stb_o      = bus_reg;
  assign wb_we_o       = bus_reg;
  assign wb_dat_o      = dat_reg;
  assign o_busy        = bus_reg;
  assign o_timeout_err = to_err_reg;
  assign o_bus_err     = bus_err_reg;

  assign tick   = i_enable && (pre_cnt_reg == PRE_LAST);
  assign launch = (state_reg == ST_IDLE) && i_enable && (tick || pending_reg);

  // A mode differing from the one used at the last launch, or the first
  // launch after a disable, starts that mode's sequence from the beginning.
  assign restart      = !mode_valid_reg || (prev_mode_reg != i_mode);
  assign walk_idx_sel = restart ? 2'd0 : walk_idx_reg + 2'd1;
  assign blink_sel    = restart ? 1'b1 : ~blink_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_walk
      assign walk_onehot[gi] = (walk_idx_sel == 2'(gi));
    end
  endgenerate

  // Pattern selection for the write launched this cycle.
  always_comb begin
    pattern = 7'h00;
    case (i_mode)
      MODE_OFF:    pattern = 7'h00;
      MODE_WALK:   pattern = {3'b000, walk_onehot};
      MODE_BLINK:  pattern = blink_sel ? 7'h7F : 7'h00;
      MODE_STATUS: pattern = i_status;
      default:     pattern = 7'h00;
    endcase
  end

  // Prescaler and pending-step bookkeeping.
  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    pending_next = pending_reg;
    if (!i_enable) begin
      pre_cnt_next = '0;
      pending_next = 1'b0;
    end else begin
      pre_cnt_next = tick ? '0 : pre_cnt_reg + PRE_W'(1);
      if (launch) begin
        pending_next = 1'b0;
      end else if (tick && (state_reg != ST_IDLE)) begin
        pending_next = 1'b1;
      end
    end
  end

  // Sequence position per mode, advanced only when a write launches.
  always_comb begin
    walk_idx_next   = walk_idx_reg;
    blink_next      = blink_reg;
    prev_mode_next  = prev_mode_reg;
    mode_valid_next = mode_valid_reg;
    if (!i_enable) begin
      mode_valid_next = 1'b0;
    end else if (launch) begin
      mode_valid_next = 1'b1;
      prev_mode_next  = i_mode;
      if (i_mode == MODE_WALK) begin
        walk_idx_next = walk_idx_sel;
      end
      if (i_mode == MODE_BLINK) begin
        blink_next = blink_sel;
      end
    end
  end

  // Bus FSM: launch from IDLE, finish on ack, abort on err or timeout.
  always_comb begin
    state_next  = state_reg;
    bus_next    = bus_reg;
    dat_next    = dat_reg;
    to_cnt_next = to_cnt_reg;
    set_to      = 1'b0;
    set_be      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          state_next  = ST_REQ;
          bus_next    = 1'b1;
          dat_next    = {{(DATA_WIDTH-7){1'b0}}, pattern};
          to_cnt_next = '0;
        end
      end
      ST_REQ: begin
        if (wb_ack_i) begin
          state_next = ST_IDLE;
          bus_next   = 1'b0;
        end else if (wb_err_i) begin
          state_next = ST_IDLE;
          bus_next   = 1'b0;
          set_be     = 1'b1;
        end else if (to_cnt_reg == TO_LAST) begin
          state_next = ST_IDLE;
          bus_next   = 1'b0;
          set_to     = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        bus_next   = 1'b0;
      end
    endcase
  end

  // Sticky error flags; a new error outranks a clear in the same cycle.
  always_comb begin
    to_err_next  = set_to ? 1'b1 : (i_clr_err ? 1'b0 : to_err_reg);
    bus_err_next = set_be ? 1'b1 : (i_clr_err ? 1'b0 : bus_err_reg);
  end

  // Prescaler, pending and sequence state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_reg    <= '0;
      pending_reg    <= 1'b0;
      walk_idx_reg   <= 2'd0;
      blink_reg      <= 1'b0;
      prev_mode_reg  <= 2'd0;
      mode_valid_reg <= 1'b0;
    end else begin
      pre_cnt_reg    <= pre_cnt_next;
      pending_reg    <= pending_next;
      walk_idx_reg   <= walk_idx_next;
      blink_reg      <= blink_next;
      prev_mode_reg  <= prev_mode_next;
      mode_valid_reg <= mode_valid_next;
    end
  end

  // FSM state, bus outputs and error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      bus_reg     <= 1'b0;
      dat_reg     <= '0;
      to_cnt_reg  <= '0;
      to_err_reg  <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_reg     <= bus_next;
      dat_reg     <= dat_next;
      to_cnt_reg  <= to_cnt_next;
      to_err_reg  <= to_err_next;
      bus_err_reg <= bus_err_next;
    end
  end

endmodule

// File: tb/tb_led_seq_wbm.sv
// tb_led_seq_wbm: directed, table-driven bench for led_seq_wbm with a small
// Wishbone slave model (ack / never-ack / err after a programmable delay).
module tb_led_seq_wbm;

  localparam int STEP = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        i_enable = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [6:0]  i_status = 7'd0;
  logic        i_clr_err = 1'b0;
  logic        o_busy;
  logic        o_timeout_err;
  logic        o_bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave behaviour: 0 = ack, 1 = never respond, 2 = err; after s_delay cycles.
  int s_kind  = 0;
  int s_delay = 1;
  int s_cnt   = 0;

  led_seq_wbm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .LED_ADDR(32'h0),
    .STEP_CYCLES(STEP), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .i_enable(i_enable), .i_mode(i_mode), .i_status(i_status),
    .i_clr_err(i_clr_err), .o_busy(o_busy),
    .o_timeout_err(o_timeout_err), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o) begin
        s_cnt    = s_cnt + 1;
        wb_ack_i = (s_kind == 0) && (s_cnt >= s_delay);
        wb_err_i = (s_kind == 2) && (s_cnt >= s_delay);
      end else begin
        s_cnt    = 0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic bound_fail(input string name, input int bound);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no event within %0d cycles (got timeout, expected event)", name, bound);
  endtask

  task automatic wait_rise(input string name, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (wb_stb_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail(name, bound);
  endtask

  task automatic measure_beat(input string name, output int len, output bit stable);
    logic [31:0] d0;
    bit          done;
    d0     = wb_dat_o;
    len    = 1;
    stable = 1'b1;
    done   = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!wb_stb_o) begin
        done = 1'b1;
        break;
      end
      len++;
      if (wb_dat_o !== d0) stable = 1'b0;
    end
    if (!done) bound_fail(name, 60);
  endtask

  task automatic quiesce();
    bit idle;
    i_enable = 1'b0;
    idle     = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!wb_stb_o) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) bound_fail("quiesce", 60);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int mode;
    int status;
    int kind;
    int delay;
    int exp_dat;
    int exp_len;
    int exp_to;
    int exp_be;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit          ok;
    int          len;
    bit          stable;
    int          k;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({wb_cyc_o, wb_stb_o, wb_we_o, o_busy}), 64'h0);
    check("rst_err", 64'({o_timeout_err, o_bus_err}), 64'h0);
    check("rst_dat", 64'(wb_dat_o), 64'h0);
    check("rst_sel_adr", 64'({wb_sel_o, wb_adr_o}), 64'({4'hF, 32'h0}));

    //          mode stat kind dly  dat    len  to be
    vecs[0]  = '{1,  0,   0,   1,   'h01,  1,   0, 0};
    vecs[1]  = '{1,  0,   0,   1,   'h02,  1,   0, 0};
    vecs[2]  = '{1,  0,   0,   1,   'h04,  1,   0, 0};
    vecs[3]  = '{1,  0,   0,   1,   'h08,  1,   0, 0};
    vecs[4]  = '{1,  0,   0,   1,   'h01,  1,   0, 0};
    vecs[5]  = '{2,  0,   0,   1,   'h7F,  1,   0, 0};
    vecs[6]  = '{2,  0,   0,   1,   'h00,  1,   0, 0};
    vecs[7]  = '{2,  0,   0,   1,   'h7F,  1,   0, 0};
    vecs[8]  = '{3,  'h55,0,   1,   'h55,  1,   0, 0};
    vecs[9]  = '{2,  0,   0,   1,   'h7F,  1,   0, 0};
    vecs[10] = '{1,  0,   2,   1,   'h01,  1,   0, 1};
    vecs[11] = '{1,  0,   1,   1,   'h02,  16,  1, 1};
    vecs[12] = '{1,  0,   0,   1,   'h04,  1,   1, 1};

    i_enable = 1'b1;
    i_mode   = 2'd1;
    s_kind   = 0;
    s_delay  = 1;
    rst      = 1'b1;

    for (int i = 0; i < 13; i++) begin
      i_mode   = 2'(vecs[i].mode);
      i_status = 7'(vecs[i].status);
      s_kind   = vecs[i].kind;
      s_delay  = vecs[i].delay;
      wait_rise($sformatf("vec%0d_rise", i), 40, ok);
      if (!ok) continue;
      check($sformatf("vec%0d_dat", i), 64'(wb_dat_o), 64'(vecs[i].exp_dat));
      check($sformatf("vec%0d_ctl", i), 64'({wb_cyc_o, wb_we_o, o_busy, wb_sel_o, wb_adr_o}),
            64'({3'b111, 4'hF, 32'h0}));
      measure_beat($sformatf("vec%0d_fall", i), len, stable);
      check($sformatf("vec%0d_len", i), 64'(len), 64'(vecs[i].exp_len));
      check($sformatf("vec%0d_stable", i), 64'(stable), 64'h1);
      check($sformatf("vec%0d_flags", i), 64'({o_timeout_err, o_bus_err, o_busy}),
            64'({vecs[i].exp_to[0], vecs[i].exp_be[0], 1'b0}));
    end

    // Clear pulse with no new error clears both flags
    quiesce();
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
    check("clr_flags", 64'({o_timeout_err, o_bus_err}), 64'h0);

    // Clear asserted in the very cycle the timeout fires: the set wins
    s_kind   = 1;
    i_mode   = 2'd1;
    i_enable = 1'b1;
    wait_rise("clrfire_rise", 20, ok);
    if (ok) begin
      repeat (TMO - 1) @(negedge clk);
      check("clrfire_stb_held", 64'(wb_stb_o), 64'h1);
      i_clr_err = 1'b1;
      @(negedge clk);
      i_clr_err = 1'b0;
      check("clrfire_stb_drop", 64'(wb_stb_o), 64'h0);
      check("clrfire_flags", 64'({o_timeout_err, o_bus_err}), 64'({1'b1, 1'b0}));
    end

    // Slow ack: ticks during a long beat collapse into one pending launch
    quiesce();
    s_kind   = 0;
    s_delay  = 10;
    i_mode   = 2'd1;
    i_enable = 1'b1;
    wait_rise("pend_rise", 20, ok);
    if (ok) begin
      check("pend_dat0", 64'(wb_dat_o), 64'h01);
      measure_beat("pend_fall", len, stable);
      check("pend_len", 64'(len), 64'd10);
      s_delay = 1;
      @(negedge clk);
      check("pend_gap_stb", 64'(wb_stb_o), 64'h1);
      check("pend_dat1", 64'(wb_dat_o), 64'h02);
      measure_beat("pend_fall1", len, stable);
      check("pend_len1", 64'(len), 64'd1);
      wait_rise("pend_rise2", 20, ok);
      if (ok) check("pend_dat2", 64'(wb_dat_o), 64'h04);
    end

    // Reset mid-REQ drops the bus at once; restart latency is STEP cycles
    quiesce();
    s_kind   = 1;
    i_mode   = 2'd1;
    i_enable = 1'b1;
    wait_rise("rstreq_rise", 20, ok);
    if (ok) begin
      #2;
      rst = 1'b0;
      #1;
      check("rstreq_ctl", 64'({wb_cyc_o, wb_stb_o, wb_we_o, o_busy}), 64'h0);
      check("rstreq_dat", 64'(wb_dat_o), 64'h0);
      @(negedge clk);
      s_kind  = 0;
      s_delay = 1;
      rst     = 1'b1;
      k = 0;
      ok = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        k++;
        if (wb_stb_o) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) bound_fail("rstreq_relaunch", 20);
      else begin
        check("rstreq_latency", 64'(k), 64'(STEP));
        check("rstreq_dat1", 64'(wb_dat_o), 64'h01);
        check("rstreq_flags", 64'({o_timeout_err, o_bus_err}), 64'h0);
      end
    end

    // Disabled: no strobe ever
    quiesce();
    k = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (wb_stb_o || o_busy) k++;
    end
    check("disabled_no_stb", 64'(k), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_seq_wbm.md
Name: led_seq_wbm

Overview:
- Wishbone master that sequences the board LED register (4 user LEDs plus green/blue/red on data bits 0..6).
- A prescaler generates step ticks. On each tick the block computes the next pattern for the selected mode and performs one single-beat Wishbone write to LED_ADDR.
- Sits between the top-level status/mode logic and the LED register slave, so the LEDs animate without CPU involvement.

Parameters:
- DATA_WIDTH, 32, Wishbone data width in bits.
- ADDR_WIDTH, 32, Wishbone address width in bits.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- LED_ADDR, 0, address of the LED register.
- STEP_CYCLES, 25000000, clk cycles per pattern step; must be >= 2.
- ACK_TIMEOUT, 16, maximum cycles in REQ without ack/err before abort; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- wb_adr_o  out  ADDR_WIDTH  address; always LED_ADDR.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data; unused.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  SELECT_WIDTH  byte select; all ones.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- i_enable  in  1  run the sequencer.
- i_mode  in  2  pattern mode: 0=off, 1=walk, 2=blink, 3=status.
- i_status  in  7  direct LED image used in mode 3.
- i_clr_err  in  1  clears the sticky error flags.
- o_busy  out  1  Wishbone transaction in flight.
- o_timeout_err  out  1  sticky: ack timeout occurred.
- o_bus_err  out  1  sticky: wb_err_i seen.

Behaviour:
- Reset (rst low, asynchronous assertion): all outputs and state clear.
  - Cleared to 0: cyc/stb/we, wb_dat_o, o_busy, both error flags, prescaler, pending, walk index, blink phase, FSM state (IDLE).
  - Constants: wb_adr_o=LED_ADDR, wb_sel_o=all ones.
  - Reset mid-transaction drops cyc/stb immediately; no completion is awaited.
- Prescaler: counts 0..STEP_CYCLES-1 while i_enable=1. tick=1 for one cycle when count==STEP_CYCLES-1, then count wraps to 0. With i_enable=0 the count is held at 0 and there are no ticks.
- Pending: a tick while the FSM is not IDLE sets pending. Multiple ticks collapse into one. Pending is cleared when a transaction launches or when i_enable=0.
- Pattern (7 bits; upper data bits always 0), computed at launch:
  - Mode 0: 0x00.
  - Mode 1: one-hot across bits 0..3, bits 4..6 = 0. Sequence 0x01, 0x02, 0x04, 0x08, then wraps to 0x01. The first walk launch after entering mode 1 (or after a disable) sends 0x01.
  - Mode 2: alternates 0x7F / 0x00, starting 0x7F after mode entry or disable.
  - Mode 3: i_status sampled at the launch edge.
  - A mode change between launches restarts that mode's sequence; the previous mode is registered at launch.
- FSM states IDLE, REQ.
  - IDLE: when (tick | pending) and i_enable, on the next edge load wb_dat_o, assert cyc=stb=we=1, set o_busy=1, go to REQ. Latency is tick at edge N -> stb high after edge N+1.
  - REQ: hold all bus outputs stable. Exactly one of the following applies, with priority ack > err > timeout:
    - wb_ack_i=1: on the next edge drop cyc/stb/we, set busy=0, return to IDLE. The first ack ends the beat, so there is exactly one write per step even if the slave acks again.
    - wb_err_i=1: drop the bus, set o_bus_err, go to IDLE.
    - No ack/err for ACK_TIMEOUT cycles in REQ: drop the bus, set o_timeout_err, go to IDLE.
  - i_enable falling during REQ: the transaction still completes or aborts normally. No new launch occurs while disabled.
  - Returning to IDLE with pending set launches on the next edge; the back-to-back gap is one idle cycle.
- Error flags: a set in the same cycle as i_clr_err wins. Error flags do not stop sequencing.

Test Plan:
- STEP_CYCLES=4, ACK_TIMEOUT=16, mode 1; slave acks 1 cycle after stb -> writes 0x01, 0x02, 0x04, 0x08, 0x01, each a single cyc/stb/we beat at addr 0, sel=0xF.
- Mode 2, then switch to mode 3 with i_status=0x55 after 3 steps -> 0x7F, 0x00, 0x7F, then 0x55. Switching back to mode 2 restarts at 0x7F.
- Slave never acks -> stb dropped after 16 REQ cycles, o_timeout_err=1. The next tick still launches. i_clr_err pulsed without a new timeout clears the flag; i_clr_err asserted in the cycle the timeout fires leaves the flag at 1.
- Slave holds ack off 10 cycles with STEP_CYCLES=4 -> the intermediate ticks collapse into one pending launch one cycle after completion; no more than one write per completion.
- wb_err_i asserted in place of ack -> bus dropped next edge, o_bus_err=1, o_timeout_err stays 0.
- rst low mid-REQ -> cyc/stb/we=0 immediately. After release in mode 1, the first write is 0x01 after STEP_CYCLES cycles. i_enable=0 -> no stb ever.
